// File: rtl/load_store_unit.sv
// Load/store initiator for a synchronous block-RAM data-memory slice.
// Accepts one request at a time, checks alignment and returns the result or a fault on a valid/ready channel.
module load_store_unit #(
  parameter int         ADDR_WIDTH = 11,
  parameter logic [1:0] WIDTH_WORD = 2'b00,
  parameter logic [1:0] WIDTH_HALF = 2'b01,
  parameter logic [1:0] WIDTH_BYTE = 2'b10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_width,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault,
  output logic                  busy,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [1:0]            mem_width_mode,
  output logic                  mem_signed_mode,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_ADDR = 3'd1,
    LOAD_DATA = 3'd2,
    STORE     = 3'd3,
    RESP      = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic [1:0]            width_q, width_d;
  logic                  signed_q, signed_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  fault_q, fault_d;
  logic [31:0]           rdata_q, rdata_d;

  logic reqReserved;
  logic reqMisaligned;
  logic reqFault;
  logic memActive;

  // Half-words at offset 01 are legal; only offset 11 would straddle a word boundary.
  always_comb begin
    reqReserved   = (req_width != WIDTH_WORD) && (req_width != WIDTH_HALF) &&
                    (req_width != WIDTH_BYTE);
    reqMisaligned = ((req_width == WIDTH_WORD) && (req_addr[1:0] != 2'b00)) ||
                    ((req_width == WIDTH_HALF) && (req_addr[1:0] == 2'b11));
    reqFault      = reqReserved || reqMisaligned;
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    width_d  = width_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    fault_d  = fault_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          width_d  = req_width;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          fault_d  = reqFault;
          rdata_d  = 32'd0;
          if (reqFault) begin
            state_d = RESP;
          end else if (req_write) begin
            state_d = STORE;
          end else begin
            state_d = LOAD_ADDR;
          end
        end
      end
      LOAD_ADDR: state_d = LOAD_DATA;
      LOAD_DATA: begin
        rdata_d = mem_rdata;
        state_d = RESP;
      end
      STORE: state_d = RESP;
      RESP: begin
        if (resp_ready) begin
          fault_d = 1'b0;
          rdata_d = 32'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      width_q  <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      fault_q  <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      width_q  <= width_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      fault_q  <= fault_d;
      rdata_q  <= rdata_d;
    end
  end

  // The memory lines carry only the latched request, so req_* may change freely while busy.
  always_comb begin
    memActive       = (state_q == LOAD_ADDR) || (state_q == LOAD_DATA) || (state_q == STORE);
    req_ready       = (state_q == IDLE);
    busy            = (state_q != IDLE);
    mem_ren         = (state_q == LOAD_ADDR) || (state_q == LOAD_DATA);
    mem_wen         = (state_q == STORE);
    mem_width_mode  = 2'b00;
    mem_signed_mode = 1'b0;
    mem_addr        = '0;
    mem_wdata       = 32'd0;
    if (memActive) begin
      mem_width_mode  = width_q;
      mem_signed_mode = signed_q;
      mem_addr        = addr_q;
      mem_wdata       = wdata_q;
    end
    resp_valid = (state_q == RESP);
    resp_fault = (state_q == RESP) && fault_q;
    resp_rdata = 32'd0;
    if ((state_q == RESP) && !fault_q && !write_q) begin
      resp_rdata = rdata_q;
    end
  end

  // Protocol invariants on the memory side.
  assert property (@(posedge clk) disable iff (!reset_n) !(mem_ren && mem_wen));
  assert property (@(posedge clk) disable iff (!reset_n)
                   (state_q == LOAD_ADDR) |=> (state_q == LOAD_DATA));
  assert property (@(posedge clk) disable iff (!reset_n)
                   (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_rdata) && $stable(resp_fault)));

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the data-memory slice interface. It accepts one load/store request at a time from the execute stage and checks alignment. It then drives the slice's ren/wen/width_mode/signed_mode/addr/wdata lines with the correct timing for synchronous block RAM. It returns the result or a fault through a valid/ready response channel, and asserts busy so the pipeline stalls while a request is in flight.

Parameters:
ADDR_WIDTH, 11, byte address width, relative to the start of the slice
WIDTH_WORD, 2'b00, width code for a word access
WIDTH_HALF, 2'b01, width code for a half-word access
WIDTH_BYTE, 2'b10, width code for a byte access (2'b11 is reserved)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous reset, active low
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_write  in  1  1 = store, 0 = load
req_width  in  2  access width code
req_signed  in  1  sign-extend load data (1 = signed)
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  32  store data, LSB-aligned
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts the response
resp_rdata  out  32  load result; 0 for stores and faults
resp_fault  out  1  misaligned or reserved-width request
busy  out  1  state != IDLE
mem_ren  out  1  slice read enable
mem_wen  out  1  slice write enable
mem_width_mode  out  2  forwarded width code
mem_signed_mode  out  1  forwarded sign mode
mem_addr  out  ADDR_WIDTH  forwarded address
mem_wdata  out  32  forwarded store data
mem_rdata  in  32  formatted read data from the slice

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on reset_n.
- While reset_n is low or the unit is in IDLE: all outputs are 0 except req_ready = 1.
- States: IDLE, LOAD_ADDR, LOAD_DATA, STORE, RESP.
- All mem_* outputs decode from the state register and the latched request registers (width, signed, addr, wdata, write).
- All mem_* outputs are 0 in IDLE and RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch every request field.
  - Fault check: width 11, or word with addr[1:0] != 00, or half with addr[1:0] == 11. On fault, set fault_q = 1 and go to RESP with no memory access.
  - Otherwise a store goes to STORE and a load goes to LOAD_ADDR.
  - Half at offset 01 is legal and is passed through.
- STORE (1 cycle): mem_wen = 1, mem_ren = 0, latched fields driven on the mem_* lines. Next state is RESP.
- LOAD_ADDR (1 cycle): mem_ren = 1, latched fields driven; the RAM samples the address at this edge. Next state is LOAD_DATA.
- LOAD_DATA (1 cycle): mem_ren held at 1, fields unchanged. mem_rdata is captured into rdata_q at the end of the cycle. Next state is RESP.
- RESP:
  - resp_valid = 1; resp_fault = fault_q.
  - resp_rdata = rdata_q for a non-faulting load, otherwise 0.
  - Outputs are held stable until resp_ready. On resp_valid && resp_ready, go to IDLE and clear fault_q and rdata_q.
  - A request cannot be accepted in the same cycle as the response handshake; there is one IDLE cycle minimum between requests.
- Latency from the accept edge (cycle N), with resp_ready tied high:
  - load: resp_valid in cycle N+3
  - store: resp_valid in cycle N+2
  - fault: resp_valid in cycle N+1
- mem_ren and mem_wen are never high in the same cycle.
- mem_ren is high for exactly two consecutive cycles per load; mem_wen is high for exactly one cycle per store.
- The unit does no data formatting; sign and zero extension are done by the slice.
- req_* changes while busy are ignored, because the latched copies are driven.
- Reset asserted mid-operation: state goes to IDLE immediately and mem_wen/mem_ren drop asynchronously. No response is produced. Whether an interrupted store completed is unspecified.
- busy = 1 in every state except IDLE.

Test Plan:
- Word store then load: store addr 0x010, wdata 0xDEADBEEF → mem_wen high for 1 cycle, resp at N+2, fault 0. Then load word 0x010 → mem_ren high 2 cycles, resp_rdata = 0xDEADBEEF at N+3.
- Signed byte load: memory word 0x000000F0 at 0x020, load byte signed at 0x020 → resp_rdata = 0xFFFFFFF0. The same access unsigned → 0x000000F0.
- Faults: word at 0x013, half at 0x013, and width 11 at 0x000 → resp_fault = 1 at N+1, resp_rdata = 0, mem_ren and mem_wen never asserted. Half at 0x011 → no fault.
- Backpressure: hold resp_ready low 5 cycles after a load → resp_valid, resp_rdata and resp_fault stable throughout, req_ready stays 0. resp_ready high → IDLE on the next edge.
- Reset mid-load: pull reset_n low during LOAD_DATA → mem_ren = 0 and busy = 0 immediately, no resp_valid. After release, a word load at 0x010 completes normally.
- Input changes while busy: change req_addr and req_wdata during STORE → mem_addr and mem_wdata hold the latched values; a readback shows only the original store took effect.
